// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Covers the FSM state encoding, the register-zero constant and the packed control bundle.
package pipe_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] LU_STALL = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idexe_en;
        logic exemem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idexe_flush;
        logic exemem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_GO     = 8'b11111_000;
    localparam pipe_ctrl_t CTRL_HOLD   = 8'b00000_000;
    localparam pipe_ctrl_t CTRL_BUBBLE = 8'b00111_010;
    localparam pipe_ctrl_t CTRL_FLUSH  = 8'b11111_111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-cycle hold/advance/flush sequencing of the four pipeline registers.
// Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       erdrt,
    input  logic             mbranch,
    input  logic             mzero,
    input  logic             mwmem,
    input  logic             mm2reg,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idexe_en,
    output logic             exemem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idexe_flush,
    output logic             exemem_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       fsm_state
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [2:0] LU_LAST = 3'(LU_STALL_CYCLES - 1);

    logic [1:0] state, next_state;
    logic [7:0] wait_cnt, wait_nxt;
    logic [2:0] lu_cnt, lu_nxt;
    logic       hazard_lu, mem_busy, taken;
    logic       set_err, flush_evt;
    pipe_ctrl_t ctrl;

    assign hazard_lu = ewreg && em2reg && (erdrt != REG_ZERO) &&
                       ((id_uses_rs && (id_rs == erdrt)) ||
                        (id_uses_rt && (id_rt == erdrt)));
    assign mem_busy  = (mwmem || mm2reg) && !dmem_ready;
    assign taken     = mbranch && mzero;

    // Mealy decode: priority is mem_busy > taken > hazard_lu.
    always_comb begin
        ctrl       = CTRL_GO;
        next_state = state;
        wait_nxt   = wait_cnt;
        lu_nxt     = lu_cnt;
        set_err    = 1'b0;
        flush_evt  = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    ctrl       = CTRL_HOLD;
                    next_state = MEM_WAIT;
                    wait_nxt   = 8'd1;
                end else if (taken) begin
                    ctrl      = CTRL_FLUSH;
                    flush_evt = 1'b1;
                end else if (hazard_lu) begin
                    ctrl = CTRL_BUBBLE;
                    if (LU_STALL_CYCLES > 1) begin
                        next_state = LU_STALL;
                        lu_nxt     = 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    next_state = RUN;
                    wait_nxt   = 8'd0;
                end else if (wait_cnt == TIMEOUT) begin
                    set_err    = 1'b1;
                    next_state = RUN;
                    wait_nxt   = 8'd0;
                end else begin
                    ctrl     = CTRL_HOLD;
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    ctrl       = CTRL_HOLD;
                    next_state = MEM_WAIT;
                    wait_nxt   = 8'd1;
                    lu_nxt     = 3'd0;
                end else if (taken) begin
                    ctrl       = CTRL_FLUSH;
                    flush_evt  = 1'b1;
                    next_state = RUN;
                    lu_nxt     = 3'd0;
                end else begin
                    ctrl = CTRL_BUBBLE;
                    if (lu_cnt == LU_LAST) begin
                        next_state = RUN;
                        lu_nxt     = 3'd0;
                    end else begin
                        lu_nxt = lu_cnt + 3'd1;
                    end
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            lu_cnt   <= 3'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
            lu_cnt   <= lu_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (perf_clr) begin
            mem_err <= 1'b0;
        end else if (set_err) begin
            mem_err <= 1'b1;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign idexe_en     = ctrl.idexe_en;
    assign exemem_en    = ctrl.exemem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idexe_flush  = ctrl.idexe_flush;
    assign exemem_flush = ctrl.exemem_flush;
    assign fsm_state    = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!ctrl.pc_en),
        .clr   (perf_clr),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_evt),
        .clr   (perf_clr),
        .count (flush_cnt)
    );

endmodule
